ysyx_24100005_ifu: RTL
======================

Name: ysyx_24100005_ifu

Overview:
- Instruction fetch unit that sits directly upstream of the core top and drives its 32-bit `inst` input.
- Owns the architectural PC and issues one word-fetch at a time over a valid/ready request and valid response memory port.
- Holds each fetched instruction on a valid/ready output until the core consumes it.
- Accepts PC redirects from branch/jump resolution and discards any in-flight fetch.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, address and instruction width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, always the current PC
- imem_rsp_valid  in  1  response valid, one cycle pulse
- imem_rsp_data  in  32  fetched word
- imem_rsp_err  in  1  access fault for this response
- inst_valid  out  1  instruction available to core
- inst_ready  in  1  core consumes instruction
- inst  out  32  instruction word
- inst_pc  out  32  PC of `inst`
- inst_fault  out  1  fetch fault (memory error or misaligned PC); `inst` = 0 when set
- redirect_valid  in  1  load new PC, flush fetch
- redirect_pc  in  32  redirect target

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset values (rst high at an edge):
  - state=IDLE, pc=RESET_PC
  - imem_req_valid=0, imem_req_addr=RESET_PC
  - inst_valid=0, inst=0, inst_pc=0, inst_fault=0, discard=0
- States:
  - IDLE: one cycle after reset, then go to REQ.
  - REQ: imem_req_valid=1. Go to WAIT when imem_req_valid && imem_req_ready.
    - If pc[1:0]!=0: no request is issued; go to HOLD with inst=0, inst_pc=pc, inst_fault=1.
  - WAIT: wait for imem_rsp_valid. On response, capture inst=imem_rsp_data (0 if imem_rsp_err), inst_pc=pc, inst_fault=imem_rsp_err, and go to HOLD.
  - HOLD: inst_valid=1. On inst_ready, set pc=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC→0) and go to REQ.
- Latency:
  - Request accepted at edge E → earliest rsp_valid in cycle E+1 → inst_valid in cycle E+2.
  - Minimum 3 cycles per instruction when ready is always high.
  - At most one outstanding request.
- Redirect (highest priority, sampled every cycle outside reset):
  - REQ: pc=redirect_pc at the edge. A handshake in the same cycle is still issued to the old address, so set discard=1 and go to WAIT.
  - WAIT: pc=redirect_pc, discard=1. The next response is dropped; discard clears and the state goes to REQ.
  - HOLD: drop the held instruction (inst_valid=0 next cycle), pc=redirect_pc, go to REQ. Redirect beats a simultaneous inst_ready; the held instruction counts as not consumed and pc is not incremented.
  - IDLE: pc=redirect_pc, go to REQ.
  - A response arriving in the same cycle as a redirect in WAIT is dropped.
- imem_rsp_valid outside WAIT is ignored.
- imem_req_valid, once high, stays high with a stable address until accepted, unless a redirect changes pc. The address then changes the following cycle.
- inst, inst_pc and inst_fault are stable while inst_valid=1 and inst_ready=0.
- rst mid-transaction: returns immediately to the reset values. A response to the abandoned request, arriving while IDLE or REQ, is ignored by the rules above. The memory model must not deliver it after the new request is accepted.

Decomposition:
- Shared package ysyx_24100005_pkg:
  - IFU state encoding (IDLE, REQ, WAIT, HOLD)
  - RESET_PC default
  - the ILEN=4 increment constant
- Single module, no sub-module. The PC register plus next-PC mux is small enough to stay inline.

Test Plan:
- Reset release, memory always ready, 1-cycle response returning 32'h00000413 then 32'h00100093:
  - imem_req_addr = 8000_0000 then 8000_0004
  - inst_valid shows each word with matching inst_pc
  - 3 cycles per instruction
- Backpressure, inst_ready low for 5 cycles in HOLD:
  - inst, inst_pc, inst_fault stay constant
  - no new request is issued
  - after ready, next address = pc+4
- Redirect to 8000_0100 while in WAIT, stale response 32'hDEADBEEF arrives next cycle:
  - the stale word never appears on inst
  - next request addr = 8000_0100
- Redirect and inst_ready in the same HOLD cycle (redirect_pc 8000_0200):
  - inst_valid drops
  - next fetch = 8000_0200, not pc+4
- imem_rsp_err=1 at 8000_0008:
  - inst_fault=1, inst=0, inst_pc=8000_0008
- Redirect to 8000_0002:
  - no imem_req_valid
  - HOLD with inst_fault=1, inst_pc=8000_0002
- Redirect to FFFF_FFFC followed by a consume:
  - next address wraps to 0000_0000

Source files
------------

// File: rtl/ysyx_24100005_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding, reset PC
// and the fixed instruction length used to advance the PC.
package ysyx_24100005_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] ILEN             = 32'd4;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2,
    IFU_HOLD = 2'd3
  } ifu_state_e;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit: owns the PC, issues one word fetch at a time and holds
// the fetched instruction on a valid/ready port until the core takes it.
module ysyx_24100005_ifu
  import ysyx_24100005_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] inst_pc_q, inst_pc_d;
  logic            inst_fault_q, inst_fault_d;
  logic            discard_q, discard_d;

  logic            pc_aligned;
  logic            req_fire;

  assign pc_aligned     = is_word_aligned(pc_q);
  assign imem_req_valid = (state_q == IFU_REQ) && pc_aligned;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid     = (state_q == IFU_HOLD);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign inst_fault     = inst_fault_q;

  always_comb begin
    // NOTE: every _d signal gets its hold value first, so no path can leave one
    // unassigned and infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    inst_fault_d = inst_fault_q;
    discard_d    = discard_q;

    unique case (state_q)
      IFU_IDLE: begin
        state_d = IFU_REQ;
        if (redirect_valid) pc_d = redirect_pc;
      end

      IFU_REQ: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          // A handshake this cycle already went out to the old address.
          if (req_fire) begin
            discard_d = 1'b1;
            state_d   = IFU_WAIT;
          end
        end else if (!pc_aligned) begin
          inst_d       = '0;
          inst_pc_d    = pc_q;
          inst_fault_d = 1'b1;
          state_d      = IFU_HOLD;
        end else if (req_fire) begin
          state_d = IFU_WAIT;
        end
      end

      IFU_WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (imem_rsp_valid) begin
            discard_d = 1'b0;
            state_d   = IFU_REQ;
          end else begin
            discard_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = IFU_REQ;
          end else begin
            inst_d       = imem_rsp_err ? '0 : imem_rsp_data;
            inst_pc_d    = pc_q;
            inst_fault_d = imem_rsp_err;
            state_d      = IFU_HOLD;
          end
        end
      end

      IFU_HOLD: begin
        // Redirect wins over a simultaneous consume; the held word is dropped.
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = IFU_REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + ILEN;
          state_d = IFU_REQ;
        end
      end

      default: state_d = IFU_IDLE;
    endcase
  end

  // NOTE: registers update with non-blocking assignments so every flop samples
  // the pre-edge values; the combinational block above uses blocking ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IFU_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_fault_q <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_fault_q <= inst_fault_d;
      discard_q    <= discard_d;
    end
  end

endmodule
